// File: rtl/stage_ctrl_writer_if.sv
// -----------------------------------------------------------------------------
// stage_ctrl_writer_if
// 32-bit AXI-Stream control channel feeding one stage's configuration writer.
//   tdata  : control word (header or payload)
//   tvalid : word valid
//   tlast  : last word of the packet
//   tready : word accepted when tvalid && tready
// master = upstream control source, slave = stage_ctrl_writer.
// -----------------------------------------------------------------------------
interface stage_ctrl_writer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stage_ctrl_writer.sv
// -----------------------------------------------------------------------------
// stage_ctrl_writer
// Control-plane writer for one RMT pipeline stage. Parses configuration packets
// from the shared control stream and turns each well-formed packet addressed to
// this stage into a single-cycle write on one of the stage's tables.
//
// Ports:
//   axis_clk, areset        clock, asynchronous active-high reset
//   s_axis                  AXI-Stream slave (tdata/tvalid/tlast/tready)
//   key_off_entry_*         key-extract offset RAM write (data/addr/strobe)
//   lookup_din*             lookup CAM write (data/mask/addr/strobe)
//   action_*                action RAM write (data/addr/strobe)
//   err_cnt                 malformed-packet counter, saturates at 255
//
// Packet: word 0 = header {stage[31:28], target[27:24], addr[23:16]},
// then payload words packed LSB first into a staging buffer.
// -----------------------------------------------------------------------------
module stage_ctrl_writer #(
    parameter int STAGE              = 0,
    parameter int KEY_LEN            = 197,
    parameter int KEY_OFF            = 18,
    parameter int ACT_LEN            = 25,
    parameter int KEY_OFF_ADDR_WIDTH = 4,
    parameter int LOOKUP_ADDR_WIDTH  = 4,
    parameter int ACT_ADDR_WIDTH     = 4
) (
    input  logic                          axis_clk,
    input  logic                          areset,
    stage_ctrl_writer_if.slave            s_axis,

    output logic [KEY_OFF-1:0]            key_off_entry_out,
    output logic [KEY_OFF_ADDR_WIDTH-1:0] key_off_entry_addr,
    output logic                          key_off_entry_valid,

    output logic [KEY_LEN-1:0]            lookup_din,
    output logic [KEY_LEN-1:0]            lookup_din_mask,
    output logic [LOOKUP_ADDR_WIDTH-1:0]  lookup_din_addr,
    output logic                          lookup_din_en,

    output logic [ACT_LEN*25-1:0]         action_data_out,
    output logic [ACT_ADDR_WIDTH-1:0]     action_addr,
    output logic                          action_en,

    output logic [7:0]                    err_cnt
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int AC_LEN   = ACT_LEN * 25;
    localparam int KO_W     = (KEY_OFF + 31) / 32;
    localparam int LK_HALF  = (KEY_LEN + 31) / 32;
    localparam int LK_W     = 2 * LK_HALF;
    localparam int AC_W     = (AC_LEN + 31) / 32;
    localparam int MAX_W    = max3(KO_W, LK_W, AC_W);
    localparam int CNT_W    = $clog2(MAX_W + 1);
    localparam int MASK_LSB = LK_HALF * 32;
    // Staging buffer only as wide as the highest bit any target reads.
    localparam int BUF_BITS = max3(KEY_OFF, MASK_LSB + KEY_LEN, AC_LEN);
    localparam int ADDR_W   = max3(KEY_OFF_ADDR_WIDTH, LOOKUP_ADDR_WIDTH, ACT_ADDR_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DROP    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           tgt_q, tgt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BUF_BITS-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]     last_idx;
    logic                 hs;
    logic                 wr_word;
    logic                 commit;
    logic                 err_inc;

    logic [KEY_OFF-1:0]            ko_data_q;
    logic [KEY_OFF_ADDR_WIDTH-1:0] ko_addr_q;
    logic                          ko_vld_q;
    logic [KEY_LEN-1:0]            lk_data_q;
    logic [KEY_LEN-1:0]            lk_mask_q;
    logic [LOOKUP_ADDR_WIDTH-1:0]  lk_addr_q;
    logic                          lk_en_q;
    logic [AC_LEN-1:0]             ac_data_q;
    logic [ACT_ADDR_WIDTH-1:0]     ac_addr_q;
    logic                          ac_en_q;
    logic [7:0]                    err_q;

    logic [3:0] hdr_stage;
    logic [3:0] hdr_tgt;

    assign hdr_stage = s_axis.tdata[31:28];
    assign hdr_tgt   = s_axis.tdata[27:24];

    // The only back-pressure is the single commit cycle; this is what
    // guarantees the one-cycle gap between consecutive packets.
    assign s_axis.tready = (state_q != S_WRITE);
    assign hs            = s_axis.tvalid && s_axis.tready;

    // Index of the final required payload word for the latched target.
    always_comb begin
        case (tgt_q)
            2'd0:    last_idx = CNT_W'(KO_W - 1);
            2'd1:    last_idx = CNT_W'(LK_W - 1);
            default: last_idx = CNT_W'(AC_W - 1);
        endcase
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        addr_d  = addr_q;
        wr_word = 1'b0;
        commit  = 1'b0;
        err_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    if (hdr_stage != 4'(STAGE)) begin
                        // Another stage's packet: silently skip it.
                        if (!s_axis.tlast) state_d = S_DROP;
                    end else if (hdr_tgt > 4'd2) begin
                        err_inc = 1'b1;
                        if (!s_axis.tlast) state_d = S_DROP;
                    end else if (s_axis.tlast) begin
                        // Header with no payload.
                        err_inc = 1'b1;
                    end else begin
                        tgt_d   = hdr_tgt[1:0];
                        addr_d  = s_axis.tdata[16 +: ADDR_W];
                        cnt_d   = '0;
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (hs) begin
                    wr_word = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == last_idx) begin
                        if (s_axis.tlast) begin
                            commit  = 1'b1;
                            state_d = S_WRITE;
                        end else begin
                            // Too long: discard the tail of the packet.
                            err_inc = 1'b1;
                            state_d = S_DROP;
                        end
                    end else if (s_axis.tlast) begin
                        err_inc = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_DROP: begin
                if (hs && s_axis.tlast) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- staging buffer
    // Payload word k lands at bits [32k+31:32k]; bits past the widest field
    // are never stored.
    always_comb begin
        buf_d = buf_q;
        if (wr_word) begin
            for (int b = 0; b < BUF_BITS; b++) begin
                if (int'(cnt_q) == (b / 32)) buf_d[b] = s_axis.tdata[b % 32];
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        buf_q <= buf_d;
    end

    // ---------------------------------------------------------------- table write outputs
    // Loaded from buf_d so the final payload word is included in the same
    // edge that moves the FSM into WRITE; strobes are high for that one cycle.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            ko_data_q <= '0;
            ko_addr_q <= '0;
            ko_vld_q  <= 1'b0;
            lk_data_q <= '0;
            lk_mask_q <= '0;
            lk_addr_q <= '0;
            lk_en_q   <= 1'b0;
            ac_data_q <= '0;
            ac_addr_q <= '0;
            ac_en_q   <= 1'b0;
        end else begin
            ko_vld_q <= 1'b0;
            lk_en_q  <= 1'b0;
            ac_en_q  <= 1'b0;
            if (commit) begin
                case (tgt_q)
                    2'd0: begin
                        ko_data_q <= buf_d[KEY_OFF-1:0];
                        ko_addr_q <= addr_q[KEY_OFF_ADDR_WIDTH-1:0];
                        ko_vld_q  <= 1'b1;
                    end
                    2'd1: begin
                        lk_data_q <= buf_d[KEY_LEN-1:0];
                        lk_mask_q <= buf_d[MASK_LSB +: KEY_LEN];
                        lk_addr_q <= addr_q[LOOKUP_ADDR_WIDTH-1:0];
                        lk_en_q   <= 1'b1;
                    end
                    default: begin
                        ac_data_q <= buf_d[AC_LEN-1:0];
                        ac_addr_q <= addr_q[ACT_ADDR_WIDTH-1:0];
                        ac_en_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- error counter
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            err_q <= '0;
        end else if (err_inc && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign key_off_entry_out   = ko_data_q;
    assign key_off_entry_addr  = ko_addr_q;
    assign key_off_entry_valid = ko_vld_q;
    assign lookup_din          = lk_data_q;
    assign lookup_din_mask     = lk_mask_q;
    assign lookup_din_addr     = lk_addr_q;
    assign lookup_din_en       = lk_en_q;
    assign action_data_out     = ac_data_q;
    assign action_addr         = ac_addr_q;
    assign action_en           = ac_en_q;
    assign err_cnt             = err_q;

endmodule

// File: tb/tb_stage_ctrl_writer.sv
// -----------------------------------------------------------------------------
// tb_stage_ctrl_writer
// Directed packets into stage_ctrl_writer (STAGE = 0). A packet-level model
// decides for each whole packet whether it commits or counts as an error and
// what the table buses must then hold; a compare process checks every cycle.
// -----------------------------------------------------------------------------
module tb_stage_ctrl_writer;

    logic axis_clk = 1'b0;
    logic areset   = 1'b1;

    always #5 axis_clk = ~axis_clk;

    stage_ctrl_writer_if s_if ();

    logic [17:0]  key_off_entry_out;
    logic [3:0]   key_off_entry_addr;
    logic         key_off_entry_valid;
    logic [196:0] lookup_din;
    logic [196:0] lookup_din_mask;
    logic [3:0]   lookup_din_addr;
    logic         lookup_din_en;
    logic [624:0] action_data_out;
    logic [3:0]   action_addr;
    logic         action_en;
    logic [7:0]   err_cnt;

    stage_ctrl_writer dut (
        .axis_clk            (axis_clk),
        .areset              (areset),
        .s_axis              (s_if),
        .key_off_entry_out   (key_off_entry_out),
        .key_off_entry_addr  (key_off_entry_addr),
        .key_off_entry_valid (key_off_entry_valid),
        .lookup_din          (lookup_din),
        .lookup_din_mask     (lookup_din_mask),
        .lookup_din_addr     (lookup_din_addr),
        .lookup_din_en       (lookup_din_en),
        .action_data_out     (action_data_out),
        .action_addr         (action_addr),
        .action_en           (action_en),
        .err_cnt             (err_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model state: what each table bus must hold, and the strobe expected now.
    logic [17:0]  m_ko;
    logic [3:0]   m_ko_a;
    logic         m_ko_v;
    logic [196:0] m_lk;
    logic [196:0] m_lkm;
    logic [3:0]   m_lk_a;
    logic         m_lk_en;
    logic [624:0] m_ac;
    logic [3:0]   m_ac_a;
    logic         m_ac_en;
    int           m_err;
    bit           err_chk = 1'b0;
    bit           chk_en  = 1'b0;
    bit           gap_en  = 1'b0;

    int ko_cnt = 0;
    int lk_cnt = 0;
    int ac_cnt = 0;

    logic [31:0] pw [0:63];

    task automatic check(input string nm, input logic [639:0] act, input logic [639:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ko = '0; m_ko_a = '0; m_ko_v = 1'b0;
        m_lk = '0; m_lkm = '0; m_lk_a = '0; m_lk_en = 1'b0;
        m_ac = '0; m_ac_a = '0; m_ac_en = 1'b0;
        m_err = 0;
    endtask

    task automatic model_err();
        if (m_err < 255) m_err++;
    endtask

    // Decide the fate of a complete packet pw[0..n-1] that ended with tlast.
    task automatic model_packet(input int n);
        logic [31:0]  hdr;
        logic [639:0] flat;
        int           req;
        hdr  = pw[0];
        flat = '0;
        if (hdr[31:28] != 4'd0) return;
        if (hdr[27:24] > 4'd2) begin model_err(); return; end
        if (n == 1) begin model_err(); return; end
        req = (hdr[27:24] == 4'd0) ? 1 : (hdr[27:24] == 4'd1) ? 14 : 20;
        if (n - 1 != req) begin model_err(); return; end
        for (int k = 0; k < n - 1; k++) flat[32*k +: 32] = pw[k+1];
        case (hdr[27:24])
            4'd0: begin m_ko = flat[17:0]; m_ko_a = hdr[19:16]; m_ko_v = 1'b1; end
            4'd1: begin m_lk = flat[196:0]; m_lkm = flat[224 +: 197]; m_lk_a = hdr[19:16]; m_lk_en = 1'b1; end
            default: begin m_ac = flat[624:0]; m_ac_a = hdr[19:16]; m_ac_en = 1'b1; end
        endcase
    endtask

    // Drive words at the falling edge; each is accepted at the next rising
    // edge where tready is high. Returns at rising edge + 1.
    task automatic send(input int n, input bit last_on_end);
        int t;
        for (int i = 0; i < n; i++) begin
            if (gap_en && i > 0 && (i % 3) == 0) begin
                @(negedge axis_clk);
                s_if.tvalid = 1'b0;
                s_if.tlast  = 1'b0;
                @(posedge axis_clk);
            end
            @(negedge axis_clk);
            s_if.tdata  = pw[i];
            s_if.tvalid = 1'b1;
            s_if.tlast  = last_on_end && (i == n - 1);
            t = 0;
            while (!s_if.tready && t < 16) begin
                @(negedge axis_clk);
                t++;
            end
            if (t >= 16) begin
                n_vec++;
                n_bad++;
                $display("FAIL tready_wait: got tready=0 for %0d cycles expected 1", t);
            end
            @(posedge axis_clk);
        end
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic run_pkt(input int n);
        err_chk = 1'b0;
        send(n, 1'b1);
        model_packet(n);
        err_chk = 1'b1;
        if (m_ko_v || m_lk_en || m_ac_en) begin
            @(posedge axis_clk);
            #1;
            m_ko_v  = 1'b0;
            m_lk_en = 1'b0;
            m_ac_en = 1'b0;
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge axis_clk) begin
        if (chk_en) begin
            if (key_off_entry_valid === 1'b1) ko_cnt++;
            if (lookup_din_en === 1'b1)       lk_cnt++;
            if (action_en === 1'b1)           ac_cnt++;
            check("ko_valid",   640'(key_off_entry_valid), 640'(m_ko_v));
            check("lk_en",      640'(lookup_din_en),       640'(m_lk_en));
            check("ac_en",      640'(action_en),           640'(m_ac_en));
            check("tready",     640'(s_if.tready),         640'(!(m_ko_v || m_lk_en || m_ac_en)));
            check("ko_data",    640'(key_off_entry_out),   640'(m_ko));
            check("ko_addr",    640'(key_off_entry_addr),  640'(m_ko_a));
            check("lk_data",    640'(lookup_din),          640'(m_lk));
            check("lk_mask",    640'(lookup_din_mask),     640'(m_lkm));
            check("lk_addr",    640'(lookup_din_addr),     640'(m_lk_a));
            check("ac_data",    640'(action_data_out),     640'(m_ac));
            check("ac_addr",    640'(action_addr),         640'(m_ac_a));
            if (err_chk) check("err_cnt", 640'(err_cnt), 640'(m_err));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        model_reset();
        @(posedge axis_clk);
        #1;
        chk_en  = 1'b1;
        err_chk = 1'b1;
        repeat (2) @(posedge axis_clk);
        #2;
        areset = 1'b0;
        @(negedge axis_clk);
        check("rst_err",    640'(err_cnt), 640'(0));
        check("rst_tready", 640'(s_if.tready), 640'(1));
        check("rst_ko",     640'(key_off_entry_out), 640'(0));
        check("rst_ac",     640'(action_data_out), 640'(0));

        // Key-offset write.
        c0 = ko_cnt;
        pw[0] = 32'h0003_0000; pw[1] = 32'h0002_A5C3;
        run_pkt(2);
        check("ko1_addr",  640'(key_off_entry_addr), 640'(4'd3));
        check("ko1_entry", 640'(key_off_entry_out), 640'(18'h2A5C3));
        check("ko1_width", 640'(ko_cnt - c0), 640'(1));
        check("ko1_err",   640'(err_cnt), 640'(0));

        // Lookup write, words 1..14.
        c0 = lk_cnt;
        pw[0] = 32'h0105_0000;
        for (int i = 1; i <= 14; i++) pw[i] = i;
        run_pkt(15);
        check("lk_addr_lit", 640'(lookup_din_addr), 640'(4'd5));
        check("lk_lo",       640'(lookup_din[31:0]), 640'(32'd1));
        check("lk_hi",       640'(lookup_din[196:192]), 640'(5'h07));
        check("lk_mask_lo",  640'(lookup_din_mask[31:0]), 640'(32'd8));
        check("lk_ko_hold",  640'(key_off_entry_out), 640'(18'h2A5C3));
        check("lk_ac_hold",  640'(action_data_out), 640'(0));
        check("lk_width",    640'(lk_cnt - c0), 640'(1));

        // Action write, with tvalid dropping mid-packet.
        c0 = ac_cnt;
        gap_en = 1'b1;
        pw[0] = 32'h0207_0000;
        for (int k = 1; k <= 20; k++) pw[k] = 32'hA000_0000 + k;
        run_pkt(21);
        gap_en = 1'b0;
        check("ac_addr_lit", 640'(action_addr), 640'(4'd7));
        check("ac_lo",       640'(action_data_out[31:0]), 640'(32'hA000_0001));
        check("ac_hi",       640'(action_data_out[624:608]), 640'(17'h00014));
        check("ac_width",    640'(ac_cnt - c0), 640'(1));

        // Foreign stage, then a normal packet.
        c0 = ko_cnt + lk_cnt + ac_cnt;
        pw[0] = 32'h1003_0000; pw[1] = 32'h1234_5678;
        run_pkt(2);
        check("fs_strobes", 640'(ko_cnt + lk_cnt + ac_cnt - c0), 640'(0));
        check("fs_err",     640'(err_cnt), 640'(0));
        pw[0] = 32'h0009_0000; pw[1] = 32'h0001_2345;
        run_pkt(2);
        check("ko2_addr",  640'(key_off_entry_addr), 640'(4'd9));
        check("ko2_entry", 640'(key_off_entry_out), 640'(18'h12345));

        // Malformed packets.
        c0 = ko_cnt + lk_cnt + ac_cnt;
        pw[0] = 32'h0102_0000; pw[1] = 32'h1; pw[2] = 32'h2; pw[3] = 32'h3;
        run_pkt(4);
        check("bad_short_err", 640'(err_cnt), 640'(1));
        pw[0] = 32'h0004_0000; pw[1] = 32'h1111; pw[2] = 32'h2222; pw[3] = 32'h3333;
        run_pkt(4);
        check("bad_long_err",  640'(err_cnt), 640'(2));
        check("bad_long_addr", 640'(key_off_entry_addr), 640'(4'd9));
        pw[0] = 32'h0F00_0000; pw[1] = 32'h0;
        run_pkt(2);
        check("bad_tgt_err", 640'(err_cnt), 640'(3));
        pw[0] = 32'h0201_0000;
        run_pkt(1);
        check("bad_hdr_only", 640'(err_cnt), 640'(4));
        check("bad_strobes",  640'(ko_cnt + lk_cnt + ac_cnt - c0), 640'(0));

        // Reset in the middle of an action packet.
        pw[0] = 32'h0203_0000;
        for (int k = 1; k <= 10; k++) pw[k] = 32'h5555_0000 + k;
        err_chk = 1'b0;
        send(11, 1'b0);
        #1;
        areset = 1'b1;
        model_reset();
        err_chk = 1'b1;
        repeat (2) @(posedge axis_clk);
        #2;
        areset = 1'b0;
        check("mid_rst_err",  640'(err_cnt), 640'(0));
        check("mid_rst_ac",   640'(action_data_out), 640'(0));
        check("mid_rst_lk",   640'(lookup_din), 640'(0));
        check("mid_rst_addr", 640'(key_off_entry_addr), 640'(0));
        pw[0] = 32'h000A_0000; pw[1] = 32'hFFFF_FFFF;
        run_pkt(2);
        check("ko3_addr",  640'(key_off_entry_addr), 640'(4'hA));
        check("ko3_entry", 640'(key_off_entry_out), 640'(18'h3FFFF));
        check("ko3_ac",    640'(action_data_out), 640'(0));

        // Error counter saturation.
        pw[0] = 32'h0F00_0000;
        for (int i = 0; i < 256; i++) run_pkt(1);
        check("err_sat", 640'(err_cnt), 640'(8'd255));
        pw[0] = 32'h0F00_0000;
        run_pkt(1);
        check("err_sat_hold", 640'(err_cnt), 640'(8'd255));

        repeat (3) @(posedge axis_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
